// File: rtl/data_mem_responder_pkg.sv
// Shared constants and address decode for the data-memory responder.
// Imported by the responder top and its debug FIFO.
package data_mem_responder_pkg;

   localparam logic [15:0] MMIO_PAGE    = 16'hFF00;
   localparam logic [15:0] MMIO_CYCLE   = MMIO_PAGE + 16'h0000;
   localparam logic [15:0] MMIO_DBG_TX  = MMIO_PAGE + 16'h0004;
   localparam logic [15:0] MMIO_SCRATCH = MMIO_PAGE + 16'h0008;

   typedef enum logic [2:0] {
      RGN_RAM,
      RGN_CYCLE,
      RGN_DBG,
      RGN_SCRATCH,
      RGN_UNMAPPED
   } region_e;

   function automatic region_e decode_region(
      input logic [15:0] addr,
      input logic [16:0] ram_bytes
   );
      logic [15:0] wa;
      region_e     r;
      wa = {addr[15:2], 2'b00};
      r  = RGN_UNMAPPED;
      unique case (1'b1)
         ({1'b0, wa} < ram_bytes): r = RGN_RAM;
         (wa == MMIO_CYCLE):       r = RGN_CYCLE;
         (wa == MMIO_DBG_TX):      r = RGN_DBG;
         (wa == MMIO_SCRATCH):     r = RGN_SCRATCH;
         default:                  r = RGN_UNMAPPED;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_mem_responder_dbg_tx_fifo.sv
// Debug transmit FIFO, first-word fall-through, sticky overflow.
// Pointers carry an extra wrap bit so full and empty are distinct.
module dbg_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [31:0]              data_i,
   output logic [31:0]              data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     overflow_o
);
   import data_mem_responder_pkg::*;

   localparam int IW = $clog2(DEPTH);

   logic [31:0] mem_q [DEPTH];
   logic [IW:0] wr_ptr_q, wr_ptr_d;
   logic [IW:0] rd_ptr_q, rd_ptr_d;
   logic        ovf_q, ovf_d;
   logic        full;
   logic        pop_ok;
   logic        push_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                    (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
   assign pop_ok  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok = push_i && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !push_ok) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[IW-1:0]] <= data_i;
   end

   assign data_o     = empty_o ? '0 : mem_q[rd_ptr_q[IW-1:0]];
   assign count_o    = wr_ptr_q - rd_ptr_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data RAM plus MMIO page (cycle counter, scratch, debug FIFO).
// Loads are combinational; stores commit on the rising edge.
module data_mem_responder #(
   parameter int RAM_WORDS = 1024,
   parameter int DBG_DEPTH = 4
) (
   input  logic        CK_REF,
   input  logic        RST_N,
   input  logic        HALT,
   input  logic        MEM_ACCESS_READ_WRN,
   input  logic [15:0] MEM_ACCESS_ADDRESS_BUS,
   input  logic [31:0] MEM_ACCESS_DATA_OUT_BUS,
   output logic [31:0] MEM_ACCESS_DATA_IN_BUS,
   input  logic        DBG_POP,
   output logic        DBG_VALID,
   output logic [31:0] DBG_DATA,
   output logic        DBG_OVERFLOW,
   output logic        ADDR_ERR
);
   import data_mem_responder_pkg::*;

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam int          CW        = $clog2(DBG_DEPTH) + 1;
   localparam logic [16:0] RAM_BYTES = 17'(RAM_WORDS * 4);

   logic [31:0]   ram_q [RAM_WORDS];
   logic [31:0]   cycle_q, cycle_d;
   logic [31:0]   scratch_q, scratch_d;
   logic          addr_err_q, addr_err_d;
   region_e       rgn;
   logic          wr_en;
   logic          ram_we;
   logic [AW-1:0] ram_idx;
   logic [CW-1:0] dbg_count;
   logic          dbg_empty;

   assign rgn     = decode_region(MEM_ACCESS_ADDRESS_BUS, RAM_BYTES);
   assign wr_en   = !MEM_ACCESS_READ_WRN && !HALT;
   assign ram_idx = MEM_ACCESS_ADDRESS_BUS[AW+1:2];
   // RAM has no reset, so drop a store on an edge that lands in reset.
   assign ram_we  = wr_en && (rgn == RGN_RAM) && RST_N;

   always_ff @(posedge CK_REF) begin
      if (ram_we) ram_q[ram_idx] <= MEM_ACCESS_DATA_OUT_BUS;
   end

   always_comb begin
      cycle_d    = HALT ? cycle_q : cycle_q + 32'd1;
      scratch_d  = scratch_q;
      addr_err_d = addr_err_q;
      if (wr_en && rgn == RGN_SCRATCH) scratch_d = MEM_ACCESS_DATA_OUT_BUS;
      if (wr_en && rgn == RGN_UNMAPPED) addr_err_d = 1'b1;
   end

   always_ff @(posedge CK_REF or negedge RST_N) begin
      if (!RST_N) begin
         cycle_q    <= '0;
         scratch_q  <= '0;
         addr_err_q <= 1'b0;
      end else begin
         cycle_q    <= cycle_d;
         scratch_q  <= scratch_d;
         addr_err_q <= addr_err_d;
      end
   end

   dbg_tx_fifo #(
      .DEPTH (DBG_DEPTH)
   ) u_dbg_fifo (
      .clk        (CK_REF),
      .rst_n      (RST_N),
      .push_i     (wr_en && rgn == RGN_DBG),
      .pop_i      (DBG_POP),
      .data_i     (MEM_ACCESS_DATA_OUT_BUS),
      .data_o     (DBG_DATA),
      .count_o    (dbg_count),
      .empty_o    (dbg_empty),
      .overflow_o (DBG_OVERFLOW)
   );

   always_comb begin
      MEM_ACCESS_DATA_IN_BUS = '0;
      unique case (rgn)
         RGN_RAM:     MEM_ACCESS_DATA_IN_BUS = ram_q[ram_idx];
         RGN_CYCLE:   MEM_ACCESS_DATA_IN_BUS = cycle_q;
         RGN_DBG:     MEM_ACCESS_DATA_IN_BUS = {{(32-CW){1'b0}}, dbg_count};
         RGN_SCRATCH: MEM_ACCESS_DATA_IN_BUS = scratch_q;
         default:     MEM_ACCESS_DATA_IN_BUS = '0;
      endcase
   end

   assign DBG_VALID = !dbg_empty;
   assign ADDR_ERR  = addr_err_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder sitting on the far end of the CPU's `MEM_ACCESS_*` bus: it serves loads and stores issued by the CPU's memory-access stage. It contains a word-organised data RAM plus a small memory-mapped register page: a free-running cycle counter, a scratch register and a debug transmit FIFO drained by the testbench or SoC. Reads are zero-wait combinational so that the CPU's end-of-cycle load latch captures them; writes commit on the clock edge.

## Interface
- `RAM_WORDS`, 1024: number of 32-bit RAM words. Power of two, ≤ 8192.
- `DBG_DEPTH`, 4: debug FIFO entries. Power of two, ≥ 2.

- `CK_REF`  in  1  clock; all state changes on rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `HALT`  in  1  CPU halt; suppresses writes and freezes the counter.
- `MEM_ACCESS_READ_WRN`  in  1  1 = read/idle, 0 = write.
- `MEM_ACCESS_ADDRESS_BUS`  in  16  byte address.
- `MEM_ACCESS_DATA_OUT_BUS`  in  32  store data from the CPU.
- `MEM_ACCESS_DATA_IN_BUS`  out  32  load data to the CPU. Combinational.
- `DBG_POP`  in  1  consumer pops the FIFO head.
- `DBG_VALID`  out  1  FIFO non-empty.
- `DBG_DATA`  out  32  FIFO head, first-word fall-through.
- `DBG_OVERFLOW`  out  1  sticky: a push was dropped because the FIFO was full.
- `ADDR_ERR`  out  1  sticky: a write targeted an unmapped address.

## Operation
- Address map (`addr[1:0]` ignored everywhere; accesses are whole-word):
  - RAM: `0x0000` to `RAM_WORDS*4-1`. The word index is `addr[log2(RAM_WORDS)+1:2]`.
  - `0xFF00` CYCLE: read-only. Writes are ignored and do not set `ADDR_ERR`.
  - `0xFF04` DBG_TX: a write pushes data. A read returns `{zeros, count}`, where count is the FIFO occupancy.
  - `0xFF08` SCRATCH: read/write.
  - Anything else: reads return 0. Writes are dropped and set `ADDR_ERR`.
- Reads have no side effects. The CPU idles with READ_WRN=1 and address 0, so it continuously reads RAM word 0; this must be harmless.
- Write condition: `READ_WRN==0 && !HALT`, committed at the rising edge.
- CYCLE increments by 1 on each edge while `!HALT`, wrapping from `0xFFFF_FFFF` to 0.

Debug FIFO:
- Push: a qualifying write to `0xFF04`.
- Pop: `DBG_POP && DBG_VALID`. `DBG_POP` while empty is ignored.
- Full + push without pop: the data is dropped and `DBG_OVERFLOW` is set.
- Full + push + pop in the same cycle: both occur, count unchanged, no overflow.
- Empty + push + pop in the same cycle: only the push occurs.
- `DBG_POP` is honoured regardless of `HALT`.

## Timing
- Read latency is 0 cycles: `MEM_ACCESS_DATA_IN_BUS` is a pure function of the address and current state.
- Writes are visible to reads in the cycle after the commit edge. There is no same-cycle write-to-read bypass.
- A FIFO push appears on `DBG_VALID`/`DBG_DATA` one cycle after the push edge.
- Reset values:
  - CYCLE = 0, SCRATCH = 0, FIFO empty (`DBG_VALID`=0, `DBG_DATA`=0).
  - `DBG_OVERFLOW`=0, `ADDR_ERR`=0.
  - `MEM_ACCESS_DATA_IN_BUS` shows RAM word 0.
- The RAM array is not reset; its contents are undefined until written.
- Reset asserted mid-operation clears all registers immediately (asynchronously). A write on the edge coinciding with reset is lost. RAM is unaffected.

## Structure
- Shared package holds:
  - Address constants `MMIO_CYCLE`, `MMIO_DBG_TX`, `MMIO_SCRATCH`.
  - The page base `0xFF00`.
  - A region-decode enum: RAM, CYCLE, DBG, SCRATCH, UNMAPPED.
- One sub-module, `dbg_tx_fifo`:
  - Parameterised depth.
  - Pointers one bit wider than the index (wrap detection).
  - Push/pop, count, full/empty and overflow outputs.
- RAM array, decode, counter and read mux live in the top module.

## Test plan
- Reset with counter: release reset with HALT=0 and hold idle 10 cycles. Then read `0xFF00` → 10 (±0 relative to release edge). All sticky flags stay 0.
- RAM write/read: write `0xDEADBEEF` to `0x0010`, then read `0x0010` → `0xDEADBEEF`. Read `0x0013` → same word. Read `0x0014` → unaffected.
- HALT gating:
  - With HALT=1, write `0x1234` to `0xFF08` → SCRATCH reads 0 after HALT drops.
  - CYCLE holds its value across 5 halted cycles.
- FIFO fill and overflow: push 1..5 with `DBG_DEPTH`=4.
  - Read `0xFF04` → 4; `DBG_OVERFLOW`=1.
  - Pop 4 times → `DBG_DATA` sequence 1,2,3,4, then `DBG_VALID`=0.
- Simultaneous events:
  - FIFO full, push 9 with `DBG_POP`=1 → count stays 4, overflow stays 0, tail = 9.
  - FIFO empty, push+pop → count 1.
- Unmapped and RO: write to `0x8000` (RAM_WORDS=1024) → `ADDR_ERR`=1 and a read returns 0. Write to `0xFF00` → `ADDR_ERR` unchanged and the counter is not overwritten.
